// File: rtl/lcd_line_writer.sv
// lcd_line_writer: writes a 16-char ASCII line to one row of an HD44780 16x2 LCD (8-bit, write-only).
// Optional feature macro LCD_SKIP_UNCHANGED_EN: an update repeating the last written line causes no bus traffic.
//
// state | meaning
// PWRUP | post-reset settle wait, bus held at reset values
// INIT  | four init commands, idx selects 38/0C/01/06
// IDLE  | waiting for update or a pending request
// ADDR  | DDRAM address command for the target row
// CHAR  | data byte for column idx (0..15)
module lcd_line_writer #(
  parameter int LINE           = 0,
  parameter int PWRUP_WAIT_CYC = 750000,
  parameter int E_HIGH_CYC     = 24,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLR_WAIT_CYC   = 82000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] line_data,
  input  logic         update,
  output logic         busy,
  output logic         done,
  output logic         lcd_e,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic [7:0]   lcd_data
);

  localparam int MAX_AB  = (PWRUP_WAIT_CYC > E_HIGH_CYC) ? PWRUP_WAIT_CYC : E_HIGH_CYC;
  localparam int MAX_CD  = (CMD_WAIT_CYC > CLR_WAIT_CYC) ? CMD_WAIT_CYC : CLR_WAIT_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] LD_PWRUP = CW'(PWRUP_WAIT_CYC - 1);
  localparam logic [CW-1:0] LD_E     = CW'(E_HIGH_CYC - 1);
  localparam logic [CW-1:0] LD_CMD   = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] LD_CLR   = CW'(CLR_WAIT_CYC - 1);
  localparam logic [7:0]    ADDR_CMD = (LINE != 0) ? 8'hC0 : 8'h80;

  typedef enum logic [2:0] {ST_PWRUP, ST_INIT, ST_IDLE, ST_ADDR, ST_CHAR} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD} phase_t;

  state_t         state, state_n;
  phase_t         phase, phase_n;
  logic [3:0]     idx, idx_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           pending, pending_n;
  logic [127:0]   snapshot, snap_n;
  logic           busy_n, done_n;
  logic [7:0]     byte_val;
  logic           byte_rs;
  logic           skip;

`ifdef LCD_SKIP_UNCHANGED_EN
  logic last_valid, last_valid_n;
  assign skip = last_valid && (line_data == snapshot);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    byte_val = 8'h00;
    byte_rs  = 1'b0;
    case (state)
      ST_INIT: begin
        case (idx[1:0])
          2'd0:    byte_val = 8'h38;
          2'd1:    byte_val = 8'h0C;
          2'd2:    byte_val = 8'h01;
          default: byte_val = 8'h06;
        endcase
      end
      ST_ADDR: byte_val = ADDR_CMD;
      ST_CHAR: begin
        byte_val = snapshot[{idx, 3'b000} +: 8];
        byte_rs  = 1'b1;
      end
      default: ;
    endcase
  end

  // Bus outputs decode straight from registered state so reset drops E immediately.
  assign lcd_data = byte_val;
  assign lcd_rs   = byte_rs;
  assign lcd_rw   = 1'b0;
  assign lcd_e    = (state == ST_INIT || state == ST_ADDR || state == ST_CHAR) && (phase == PH_PULSE);

  always_comb begin
    state_n   = state;
    phase_n   = phase;
    idx_n     = idx;
    cnt_n     = cnt;
    pending_n = pending;
    snap_n    = snapshot;
    done_n    = 1'b0;
    busy_n    = 1'b1;
`ifdef LCD_SKIP_UNCHANGED_EN
    last_valid_n = last_valid;
`endif
    if (update && state != ST_IDLE) pending_n = 1'b1;

    case (state)
      ST_PWRUP: begin
        if (cnt == '0) begin
          state_n = ST_INIT;
          phase_n = PH_SETUP;
          idx_n   = 4'd0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      ST_IDLE: begin
        if (update || pending) begin
          pending_n = 1'b0;
          if (skip) begin
            done_n = 1'b1;
          end else begin
            snap_n  = line_data;
            state_n = ST_ADDR;
            phase_n = PH_SETUP;
`ifdef LCD_SKIP_UNCHANGED_EN
            last_valid_n = 1'b1;
`endif
          end
        end
      end
      default: begin
        case (phase)
          PH_SETUP: begin
            phase_n = PH_PULSE;
            cnt_n   = LD_E;
          end
          PH_PULSE: begin
            if (cnt == '0) begin
              phase_n = PH_HOLD;
              cnt_n   = (!byte_rs && byte_val == 8'h01) ? LD_CLR : LD_CMD;
            end else begin
              cnt_n = cnt - CW'(1);
            end
          end
          default: begin
            if (cnt == '0) begin
              phase_n = PH_SETUP;
              case (state)
                ST_INIT: begin
                  if (idx == 4'd3) state_n = ST_IDLE;
                  else             idx_n   = idx + 4'd1;
                end
                ST_ADDR: begin
                  state_n = ST_CHAR;
                  idx_n   = 4'd0;
                end
                ST_CHAR: begin
                  if (idx == 4'd15) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                  end else begin
                    idx_n = idx + 4'd1;
                  end
                end
                default: ;
              endcase
            end else begin
              cnt_n = cnt - CW'(1);
            end
          end
        endcase
      end
    endcase

    // Holding busy for one IDLE cycle lets a pending request restart without a busy gap.
    busy_n = (state_n != ST_IDLE) || (state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_PWRUP;
      phase    <= PH_SETUP;
      idx      <= 4'd0;
      cnt      <= LD_PWRUP;
      pending  <= 1'b0;
      snapshot <= {16{8'h20}};
      busy     <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      pending  <= pending_n;
      snapshot <= snap_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

`ifdef LCD_SKIP_UNCHANGED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_valid <= 1'b0;
    else        last_valid <= last_valid_n;
  end
`endif

endmodule

// File: tb/tb_lcd_line_writer.sv
// tb_lcd_line_writer: directed vector bench for lcd_line_writer with short timing parameters.
// Two instances share inputs: row 0 (full checking) and row 1 (address byte only).
module tb_lcd_line_writer;
  localparam int PW  = 20;
  localparam int EH  = 2;
  localparam int CMW = 5;
  localparam int CLW = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         update = 1'b0;
  logic [127:0] line_data = '0;
  logic         busy, done, lcd_e, lcd_rs, lcd_rw;
  logic [7:0]   lcd_data;
  logic         busy1, done1, lcd_e1, lcd_rs1, lcd_rw1;
  logic [7:0]   lcd_data1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_line_writer #(.LINE(0), .PWRUP_WAIT_CYC(PW), .E_HIGH_CYC(EH), .CMD_WAIT_CYC(CMW), .CLR_WAIT_CYC(CLW)) dut (
    .clk(clk), .rst_n(rst_n), .line_data(line_data), .update(update), .busy(busy), .done(done),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data));

  lcd_line_writer #(.LINE(1), .PWRUP_WAIT_CYC(PW), .E_HIGH_CYC(EH), .CMD_WAIT_CYC(CMW), .CLR_WAIT_CYC(CLW)) dut1 (
    .clk(clk), .rst_n(rst_n), .line_data(line_data), .update(update), .busy(busy1), .done(done1),
    .lcd_e(lcd_e1), .lcd_rs(lcd_rs1), .lcd_rw(lcd_rw1), .lcd_data(lcd_data1));

  // Bus monitor: bytes latched on E rise, rise/done cycle stamps, bus stability, first busy-low cycle.
  logic [8:0] mon_q[$];
  logic [8:0] mon1_q[$];
  int         rise_q[$];
  int         done_q[$];
  logic       e_prev = 1'b0;
  logic       e1_prev = 1'b0;
  logic [8:0] last_b = '0;
  int         stab_err = 0;
  int         first_low = -1;

  always @(negedge clk) begin
    if (lcd_e && !e_prev) begin
      mon_q.push_back({lcd_rs, lcd_data});
      rise_q.push_back(cyc);
      last_b = {lcd_rs, lcd_data};
    end
    if (rst_n && lcd_e && {lcd_rs, lcd_data} != last_b) stab_err++;
    if (rst_n && !lcd_e && e_prev && {lcd_rs, lcd_data} != last_b) stab_err++;
    if (lcd_e1 && !e1_prev) mon1_q.push_back({lcd_rs1, lcd_data1});
    if (done) done_q.push_back(cyc);
    if (rst_n && !busy && first_low < 0) first_low = cyc;
    e_prev  = lcd_e;
    e1_prev = lcd_e1;
  end

  typedef struct {
    logic [8:0] b;
    int         gap;
  } init_t;

  typedef struct {
    logic [127:0] txt;
    logic [127:0] exp;
  } vec_t;

  init_t itab[4];
  vec_t  vt[3];
  logic [127:0] hello_txt, hello_exp, junk_txt;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] to_line(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = s[(15-i)*8 +: 8];
    return r;
  endfunction

  task automatic clear_mon();
    mon_q.delete();
    mon1_q.delete();
    rise_q.delete();
    done_q.delete();
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL %s: busy still %b after %0d cycles", nm, busy, budget);
    end
  endtask

  task automatic wait_bytes(input string nm, input int n, input int budget);
    int k = 0;
    while (mon_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (mon_q.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s: only %0d bytes seen, wanted %0d", nm, mon_q.size(), n);
    end
  endtask

  task automatic do_update(input logic [127:0] d);
    line_data = d;
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  task automatic check_line(input string tag, input int off, input logic [127:0] exp);
    logic [7:0] eb;
    if (off < mon_q.size()) chk({tag, "_addr"}, mon_q[off], 9'h080);
    else chk({tag, "_addr_missing"}, mon_q.size(), off + 1);
    for (int j = 0; j < 16; j++) begin
      eb = exp[(15-j)*8 +: 8];
      if (off + 1 + j < mon_q.size()) chk($sformatf("%s_char%0d", tag, j), mon_q[off+1+j], {1'b1, eb});
    end
  endtask

  // Caller holds rst_n low; this releases it and checks the whole init sequence.
  task automatic check_init(input string tag);
    int rel, fall;
    clear_mon();
    first_low = -1;
    rst_n = 1'b1;
    rel = cyc;
    wait_idle({tag, "_idle"}, 200);
    fall = cyc;
    repeat (25) tick();
    chk({tag, "_nbytes"}, mon_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < mon_q.size()) begin
        chk($sformatf("%s_byte%0d", tag, i), mon_q[i], itab[i].b);
        chk($sformatf("%s_gap%0d", tag, i), rise_q[i] - ((i == 0) ? rel : rise_q[i-1]), itab[i].gap);
      end
    end
    if (mon_q.size() >= 4) chk({tag, "_busy_fall"}, fall - rise_q[3], 8);
    chk({tag, "_no_done"}, done_q.size(), 0);
  endtask

  initial begin
    itab[0] = '{b: 9'h038, gap: 21};
    itab[1] = '{b: 9'h00C, gap: 8};
    itab[2] = '{b: 9'h001, gap: 8};
    itab[3] = '{b: 9'h006, gap: 13};
    vt[0] = '{txt: "STRIKE 2 BALL 1 ", exp: 128'h53545249_4B452032_2042414C_4C203120};
    vt[1] = '{txt: "BALL 3 STRIKE 0 ", exp: 128'h42414C4C_20332053_5452494B_45203020};
    vt[2] = '{txt: 128'h00017F80_FF0A0D1B_20417E09_10C0AA55, exp: 128'h00017F80_FF0A0D1B_20417E09_10C0AA55};
    hello_txt = "HELLO WORLD 1234";
    hello_exp = 128'h48454C4C_4F20574F_524C4420_31323334;
    junk_txt  = "XXXXXXXXXXXXXXXX";

    // Reset values
    repeat (3) tick();
    chk("rst_e", lcd_e, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_rw", lcd_rw, 0);
    chk("rst_data", lcd_data, 0);
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);

    check_init("init");

    // Line-write vectors
    for (int v = 0; v < 3; v++) begin
      clear_mon();
      do_update(to_line(vt[v].txt));
      chk($sformatf("vec%0d_busy_rise", v), busy, 1);
      wait_idle($sformatf("vec%0d_idle", v), 400);
      repeat (3) tick();
      chk($sformatf("vec%0d_nbytes", v), mon_q.size(), 17);
      check_line($sformatf("vec%0d", v), 0, vt[v].exp);
      chk($sformatf("vec%0d_ndone", v), done_q.size(), 1);
      if (done_q.size() > 0 && rise_q.size() > 0)
        chk($sformatf("vec%0d_done_lat", v), done_q[0] - rise_q[0], 135);
      if (mon1_q.size() > 0) chk($sformatf("vec%0d_row1_addr", v), mon1_q[0], 9'h0C0);
    end

    // Input change mid-write must not reach the bus
    clear_mon();
    do_update(to_line(hello_txt));
    wait_bytes("mid_change_wait", 5, 200);
    line_data = to_line(junk_txt);
    wait_idle("mid_change_idle", 400);
    repeat (3) tick();
    chk("mid_change_nbytes", mon_q.size(), 17);
    check_line("mid_change", 0, hello_exp);
    if (mon1_q.size() > 0) chk("mid_change_row1_addr", mon1_q[0], 9'h0C0);

    // Reset during PULSE of char 5
    clear_mon();
    do_update(to_line(vt[0].txt));
    wait_bytes("rst_mid_wait", 7, 200);
    chk("rst_mid_e_before", lcd_e, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_e_drop", lcd_e, 0);
    chk("rst_mid_e1_drop", lcd_e1, 0);
    chk("rst_mid_busy", busy, 1);
    repeat (3) tick();
    check_init("reinit");

    // Requests during init and during a write: merged, sampled at IDLE re-entry
    rst_n = 1'b0;
    repeat (2) tick();
    clear_mon();
    first_low = -1;
    rst_n = 1'b1;
    repeat (3) tick();
    do_update(to_line(vt[0].txt));
    tick();
    do_update(to_line(vt[0].txt));
    line_data = to_line(vt[1].txt);
    wait_bytes("pend_wait", 9, 200);
    do_update(to_line(vt[2].txt));
    tick();
    do_update(to_line(vt[2].txt));
    line_data = to_line(hello_txt);
    wait_idle("pend_idle", 800);
    repeat (20) tick();
    chk("pend_nbytes", mon_q.size(), 38);
    check_line("pend_w1", 4, vt[1].exp);
    check_line("pend_w2", 21, hello_exp);
    chk("pend_ndone", done_q.size(), 2);
    if (done_q.size() >= 2) chk("pend_busy_hold", first_low - done_q[1], 1);

    // Repeat of the last written line, then changed data
    begin
      int c0;
      clear_mon();
      c0 = cyc;
      do_update(to_line(hello_txt));
`ifdef LCD_SKIP_UNCHANGED_EN
      chk("skip_busy", busy, 0);
      repeat (30) tick();
      chk("skip_nbytes", mon_q.size(), 0);
      chk("skip_ndone", done_q.size(), 1);
      if (done_q.size() > 0) chk("skip_done_lat", done_q[0] - c0, 1);
`else
      chk("repeat_busy", busy, 1);
      wait_idle("repeat_idle", 400);
      repeat (3) tick();
      chk("repeat_nbytes", mon_q.size(), 17);
      check_line("repeat", 0, hello_exp);
      chk("repeat_ndone", done_q.size(), 1);
`endif
    end
    clear_mon();
    do_update(to_line(vt[0].txt));
    wait_idle("changed_idle", 400);
    repeat (3) tick();
    chk("changed_nbytes", mon_q.size(), 17);
    check_line("changed", 0, vt[0].exp);

    chk("bus_stable", stab_err, 0);
    chk("rw_low", lcd_rw, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
